// File: rtl/ring_router_gateway_demux_n.sv
// Debug-ring gateway demultiplexer: routes DII worms to NUM_LOCAL local ports, the
// off-subnet port or onward on the ring through a 2-entry output buffer. Macro DII_DEMUX_STATS_EN adds per-destination packet counters.
module ring_router_gateway_demux_n #(
    parameter int SUBNET_BITS  = 6,
    parameter int LOCAL_SUBNET = 0,
    parameter int NUM_LOCAL    = 2,
    parameter int BUF_DEPTH    = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [15:0]                 id_base_i,
    input  logic [15:0]                 in_ring_data_i,
    input  logic                        in_ring_last_i,
    input  logic                        in_ring_valid_i,
    output logic                        in_ring_ready_o,
    output logic [NUM_LOCAL-1:0][15:0]  out_local_data_o,
    output logic [NUM_LOCAL-1:0]        out_local_last_o,
    output logic [NUM_LOCAL-1:0]        out_local_valid_o,
    input  logic [NUM_LOCAL-1:0]        out_local_ready_i,
    output logic [15:0]                 out_ext_data_o,
    output logic                        out_ext_last_o,
    output logic                        out_ext_valid_o,
    input  logic                        out_ext_ready_i,
    output logic [15:0]                 out_ring_data_o,
    output logic                        out_ring_last_o,
    output logic                        out_ring_valid_o,
    input  logic                        out_ring_ready_i
`ifdef DII_DEMUX_STATS_EN
    ,
    output logic [16*(NUM_LOCAL+2)-1:0] stat_pkts_o,
    input  logic                        stat_clr_i
`endif
);

    localparam int NDEST = NUM_LOCAL + 2;
    localparam int DW = $clog2(NDEST);
    localparam logic [DW-1:0] DEST_EXT = DW'(NUM_LOCAL);
    localparam logic [DW-1:0] DEST_RING = DW'(NUM_LOCAL + 1);

    typedef enum logic {IDLE = 1'b0, WORM = 1'b1} state_t;

    state_t state_q, state_d;
    logic [DW-1:0] dest_q, dest_d;
    logic [15:0] mem_data_q [BUF_DEPTH];
    logic        mem_last_q [BUF_DEPTH];
    logic [DW-1:0] mem_dest_q [BUF_DEPTH];
    logic        wr_ptr_q, rd_ptr_q;
    logic [1:0]  count_q;

    logic [15:0]   off_s;
    logic [DW-1:0] hdr_dest_s, enq_dest_s, head_dest_s;
    logic          accept_s, deq_s, sel_ready_s, head_last_s;
    logic [15:0]   head_data_s;

    // Header decode: local offset first, then foreign subnet, else ring.
    always_comb begin
        off_s = in_ring_data_i - id_base_i;
        if (off_s < 16'(NUM_LOCAL)) begin
            hdr_dest_s = off_s[DW-1:0];
        end else if (in_ring_data_i[15 -: SUBNET_BITS] != SUBNET_BITS'(LOCAL_SUBNET)) begin
            hdr_dest_s = DEST_EXT;
        end else begin
            hdr_dest_s = DEST_RING;
        end
    end

    assign in_ring_ready_o = !rst && (count_q < 2'd2);
    assign accept_s = in_ring_valid_i && in_ring_ready_o;
    assign enq_dest_s = (state_q == IDLE) ? hdr_dest_s : dest_q;

    // Worm tracking: the destination is latched only when a header is accepted.
    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    dest_d  = hdr_dest_s;
                    state_d = in_ring_last_i ? IDLE : WORM;
                end else begin
                    state_d = IDLE;
                end
            end
            WORM: begin
                if (accept_s && in_ring_last_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = WORM;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and latched worm destination.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dest_q  <= '0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
        end
    end

    assign head_data_s = mem_data_q[rd_ptr_q];
    assign head_last_s = mem_last_q[rd_ptr_q];
    assign head_dest_s = mem_dest_q[rd_ptr_q];

    // Ready of whichever output the head entry targets.
    always_comb begin
        sel_ready_s = 1'b0;
        for (int i = 0; i < NUM_LOCAL; i++) begin
            if (head_dest_s == DW'(i)) begin
                sel_ready_s = out_local_ready_i[i];
            end else begin
                sel_ready_s = sel_ready_s;
            end
        end
        if (head_dest_s == DEST_EXT) begin
            sel_ready_s = out_ext_ready_i;
        end else if (head_dest_s == DEST_RING) begin
            sel_ready_s = out_ring_ready_i;
        end else begin
            sel_ready_s = sel_ready_s;
        end
    end

    assign deq_s = (count_q != 2'd0) && sel_ready_s;

    // Two-entry output FIFO of {data, last, dest}.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_data_q[i] <= 16'h0000;
                mem_last_q[i] <= 1'b0;
                mem_dest_q[i] <= '0;
            end
        end else begin
            if (accept_s) begin
                mem_data_q[wr_ptr_q] <= in_ring_data_i;
                mem_last_q[wr_ptr_q] <= in_ring_last_i;
                mem_dest_q[wr_ptr_q] <= enq_dest_s;
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (deq_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({accept_s, deq_s})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Only the targeted output raises valid; data and last are broadcast.
    always_comb begin
        for (int i = 0; i < NUM_LOCAL; i++) begin
            out_local_data_o[i]  = head_data_s;
            out_local_last_o[i]  = head_last_s;
            out_local_valid_o[i] = (count_q != 2'd0) && (head_dest_s == DW'(i));
        end
        out_ext_data_o   = head_data_s;
        out_ext_last_o   = head_last_s;
        out_ext_valid_o  = (count_q != 2'd0) && (head_dest_s == DEST_EXT);
        out_ring_data_o  = head_data_s;
        out_ring_last_o  = head_last_s;
        out_ring_valid_o = (count_q != 2'd0) && (head_dest_s == DEST_RING);
    end

`ifdef DII_DEMUX_STATS_EN
    logic [NDEST-1:0][15:0] stat_q;

    // Saturating per-destination packet counters; clear beats increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_q <= '0;
        end else if (stat_clr_i) begin
            stat_q <= '0;
        end else begin
            for (int i = 0; i < NDEST; i++) begin
                if (deq_s && head_last_s && (head_dest_s == DW'(i)) && (stat_q[i] != 16'hFFFF)) begin
                    stat_q[i] <= stat_q[i] + 16'd1;
                end else begin
                    stat_q[i] <= stat_q[i];
                end
            end
        end
    end

    assign stat_pkts_o = stat_q;
`endif

endmodule
